// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter over four requesters driving a registered 4:1 data
//   mux. A grant is held while its requester keeps req asserted, for at most
//   MAX_HOLD consecutive cycles. On release the next requester is granted
//   directly, with no idle cycle in between.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   req[3:0]     per-source requests
//   I0..I3       per-source data, W bits each
//   gnt[3:0]     one-hot grant, or zero when idle
//   S1,S0        mux select, equal to the granted index
//   y            registered data of the granted source (one cycle behind gnt)
//   valid        high when y holds granted data
module mux4_rr_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4   // legal 1..15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  output logic [3:0]   gnt,
  output logic         S1,
  output logic         S0,
  output logic [W-1:0] y,
  output logic         valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t       state_q;
  logic [1:0]   sel_q;
  logic [1:0]   ptr_q;
  logic [3:0]   hold_q;
  logic [3:0]   gnt_q;
  logic [W-1:0] y_q;
  logic         valid_q;

  logic [1:0]   base;
  logic [1:0]   pick_idx;
  logic         pick_found;
  logic         release_c;
  logic [W-1:0] data_sel;

  // On release the pointer moves to sel+1 in the same edge, so the next
  // winner is scanned from sel+1 directly rather than from the stale ptr_q.
  // Scanning from sel+1 reaches sel last, which re-grants a lone
  // hold-limited requester.
  always_comb begin
    base = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    // Walk from the farthest offset back to the nearest so the closest
    // asserted request to base wins.
    for (int k = 3; k >= 0; k--) begin
      if (req[base + 2'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = base + 2'(k);
      end
    end
  end

  assign release_c = (state_q == GRANT) && (!req[sel_q] || hold_q == HOLD_MAX);

  always_comb begin
    case (sel_q)
      2'd0:    data_sel = I0;
      2'd1:    data_sel = I1;
      2'd2:    data_sel = I2;
      default: data_sel = I3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= 4'd0;
      gnt_q   <= 4'd0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (pick_found) begin
            state_q <= GRANT;
            sel_q   <= pick_idx;
            gnt_q   <= 4'b0001 << pick_idx;
            hold_q  <= 4'd1;
          end
        end
        GRANT: begin
          y_q     <= data_sel;
          valid_q <= 1'b1;
          if (release_c) begin
            ptr_q <= sel_q + 2'd1;
            if (pick_found) begin
              sel_q  <= pick_idx;
              gnt_q  <= 4'b0001 << pick_idx;
              hold_q <= 4'd1;
            end else begin
              state_q <= IDLE;
              gnt_q   <= 4'd0;
              hold_q  <= 4'd0;
            end
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign S1    = sel_q[1];
  assign S0    = sel_q[0];
  assign y     = y_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] I0, I1, I2, I3;
  logic [3:0] gnt;
  logic       S1, S0;
  logic [7:0] y;
  logic       valid;

  int n_chk  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.W(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .gnt(gnt), .S1(S1), .S0(S0), .y(y), .valid(valid)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       v;
    logic [7:0] y;
  } vec_t;

  vec_t tbl [23];
  logic [7:0] dat [4];

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Every cycle: grant is one-hot or zero, and select matches the grant.
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if (($countones(gnt) > 1) || (gnt != 4'd0 && gnt != (4'b0001 << {S1, S0}))) begin
        n_fail++;
        $display("FAIL onehot_sel at %0t: gnt=%b sel=%b%b", $time, gnt, S1, S0);
      end
    end
  end

  initial begin
    I0 = 8'h11; I1 = 8'h22; I2 = 8'hA5; I3 = 8'h44;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'hA5; dat[3] = 8'h44;
    rst = 1'b1; req = 4'd0;

    //            rst   req      gnt      v     y
    // reset with all requests, then first grant favours source 0
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 8'h11};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'h11};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
    // single source 2: hold limit then gapless re-grant
    tbl[6]  = '{1'b0, 4'b0100, 4'b0100, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA5};
    tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA5};
    tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA5};
    tbl[10] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA5};
    tbl[11] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 8'hA5};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5};
    // ptr=3: grant source 3, drop it after 2 cycles, wrap to source 0
    tbl[13] = '{1'b0, 4'b1001, 4'b1000, 1'b0, 8'hA5};
    tbl[14] = '{1'b0, 4'b1001, 4'b1000, 1'b1, 8'h44};
    tbl[15] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 8'h44};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 8'h11};
    tbl[17] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'h11};
    // reset in the middle of a grant on source 1
    tbl[18] = '{1'b0, 4'b0110, 4'b0010, 1'b0, 8'h11};
    tbl[19] = '{1'b0, 4'b0110, 4'b0010, 1'b1, 8'h22};
    tbl[20] = '{1'b1, 4'b0110, 4'b0000, 1'b0, 8'h00};
    tbl[21] = '{1'b0, 4'b0110, 4'b0010, 1'b0, 8'h00};
    tbl[22] = '{1'b0, 4'b0110, 4'b0010, 1'b1, 8'h22};

    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      chk("gnt",   i, {4'd0, gnt},   {4'd0, tbl[i].gnt});
      chk("valid", i, {7'd0, valid}, {7'd0, tbl[i].v});
      chk("y",     i, y,             tbl[i].y);
    end

    // Round robin with every source requesting: 0,1,2,3,0, four cycles each.
    rst = 1'b1; req = 4'b1111;
    @(posedge clk); #1;
    chk("rr_reset_gnt", 0, {4'd0, gnt}, 8'd0);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk("rr_gnt", k, {4'd0, gnt}, {4'd0, 4'b0001 << (((k - 1) / 4) % 4)});
      if (k == 1) begin
        chk("rr_valid", k, {7'd0, valid}, 8'd0);
      end else begin
        chk("rr_valid", k, {7'd0, valid}, 8'd1);
        chk("rr_y",     k, y, dat[((k - 2) / 4) % 4]);
      end
    end

    req = 4'd0;
    @(posedge clk); #1;
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
